// File: rtl/wishbone_to_ahb.sv
// Wishbone classic slave to AHB-Lite master bridge: one single transfer in flight,
// byte selects decoded to HSIZE/HADDR[1:0], AHB errors returned as wb_err.
module wishbone_to_ahb #(
  parameter int         ADDR_WIDTH  = 32,
  parameter int         DATA_WIDTH  = 32,
  parameter logic [3:0] HPROT_VALUE = 4'b0011
) (
  input  logic                  HCLK,
  input  logic                  HRESETn,
  input  logic                  wb_cyc,
  input  logic                  wb_stb,
  input  logic                  wb_we,
  input  logic [3:0]            wb_wstrb,
  input  logic [ADDR_WIDTH-1:0] wb_adr,
  input  logic [DATA_WIDTH-1:0] wb_dat_w,
  output logic [DATA_WIDTH-1:0] wb_dat_r,
  output logic                  wb_ack,
  output logic                  wb_err,
  output logic [ADDR_WIDTH-1:0] HADDR,
  output logic [1:0]            HTRANS,
  output logic                  HWRITE,
  output logic [2:0]            HSIZE,
  output logic [2:0]            HBURST,
  output logic [3:0]            HPROT,
  output logic                  HMASTLOCK,
  output logic [DATA_WIDTH-1:0] HWDATA,
  input  logic [DATA_WIDTH-1:0] HRDATA,
  input  logic                  HREADY,
  input  logic                  HRESP
);

  localparam logic [1:0] TR_IDLE   = 2'b00;
  localparam logic [1:0] TR_NONSEQ = 2'b10;

  typedef enum logic [2:0] {S_IDLE, S_ADDR, S_DATA, S_ERR2, S_ABORT} state_t;

  state_t                state_q, state_d;
  logic [1:0]            htrans_q, htrans_d;
  logic [ADDR_WIDTH-1:0] haddr_q, haddr_d;
  logic [2:0]            hsize_q, hsize_d;
  logic                  hwrite_q, hwrite_d;
  logic [DATA_WIDTH-1:0] hwdata_q, hwdata_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
  logic                  ack_q, ack_d;
  logic                  err_q, err_d;
  logic                  abort_q, abort_d;

  logic       req;
  logic       sel_ok;
  logic [2:0] sel_size;
  logic [1:0] sel_lane;
  logic       unused_adr_lsb;

  assign unused_adr_lsb = ^wb_adr[1:0];

  // The ack/err guard keeps a master still holding stb from re-issuing
  assign req = wb_cyc & wb_stb & ~ack_q & ~err_q;

  always_comb begin
    sel_ok   = 1'b1;
    sel_size = 3'b010;
    sel_lane = 2'b00;
    case (wb_wstrb)
      4'b1111: sel_size = 3'b010;
      4'b0011: sel_size = 3'b001;
      4'b1100: begin sel_size = 3'b001; sel_lane = 2'b10; end
      4'b0001: begin sel_size = 3'b000; sel_lane = 2'b00; end
      4'b0010: begin sel_size = 3'b000; sel_lane = 2'b01; end
      4'b0100: begin sel_size = 3'b000; sel_lane = 2'b10; end
      4'b1000: begin sel_size = 3'b000; sel_lane = 2'b11; end
      4'b0000: sel_ok = ~wb_we;
      default: sel_ok = 1'b0;
    endcase
  end

  always_comb begin
    state_d  = state_q;
    htrans_d = htrans_q;
    haddr_d  = haddr_q;
    hsize_d  = hsize_q;
    hwrite_d = hwrite_q;
    hwdata_d = hwdata_q;
    wdata_d  = wdata_q;
    rdata_d  = rdata_q;
    ack_d    = 1'b0;
    err_d    = 1'b0;
    abort_d  = abort_q;
    case (state_q)
      S_IDLE: begin
        abort_d = 1'b0;
        if (req) begin
          if (sel_ok) begin
            state_d  = S_ADDR;
            htrans_d = TR_NONSEQ;
            haddr_d  = {wb_adr[ADDR_WIDTH-1:2], sel_lane};
            hsize_d  = sel_size;
            hwrite_d = wb_we;
            wdata_d  = wb_dat_w;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      // HRESP here belongs to another master's data phase and is ignored
      S_ADDR: begin
        if (!wb_cyc) abort_d = 1'b1;
        if (HREADY) begin
          htrans_d = TR_IDLE;
          if (hwrite_q) hwdata_d = wdata_q;
          state_d = (abort_q || !wb_cyc) ? S_ABORT : S_DATA;
        end
      end
      S_DATA: begin
        if (!wb_cyc) begin
          state_d = HREADY ? S_IDLE : S_ABORT;
        end else if (HREADY) begin
          state_d = S_IDLE;
          if (HRESP) begin
            err_d = 1'b1;
          end else begin
            ack_d = 1'b1;
            if (!hwrite_q) rdata_d = HRDATA;
          end
        end else if (HRESP) begin
          state_d = S_ERR2;
        end
      end
      S_ERR2: begin
        if (HREADY) begin
          state_d = S_IDLE;
          err_d   = wb_cyc;
        end else if (!wb_cyc) begin
          state_d = S_ABORT;
        end
      end
      S_ABORT: begin
        if (HREADY) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge HCLK) begin
    if (!HRESETn) begin
      state_q  <= S_IDLE;
      htrans_q <= TR_IDLE;
      haddr_q  <= '0;
      hsize_q  <= '0;
      hwrite_q <= 1'b0;
      hwdata_q <= '0;
      wdata_q  <= '0;
      rdata_q  <= '0;
      ack_q    <= 1'b0;
      err_q    <= 1'b0;
      abort_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      htrans_q <= htrans_d;
      haddr_q  <= haddr_d;
      hsize_q  <= hsize_d;
      hwrite_q <= hwrite_d;
      hwdata_q <= hwdata_d;
      wdata_q  <= wdata_d;
      rdata_q  <= rdata_d;
      ack_q    <= ack_d;
      err_q    <= err_d;
      abort_q  <= abort_d;
    end
  end

  assign HTRANS    = htrans_q;
  assign HADDR     = haddr_q;
  assign HSIZE     = hsize_q;
  assign HWRITE    = hwrite_q;
  assign HWDATA    = hwdata_q;
  assign HBURST    = 3'b000;
  assign HPROT     = HPROT_VALUE;
  assign HMASTLOCK = 1'b0;
  assign wb_dat_r  = rdata_q;
  assign wb_ack    = ack_q;
  assign wb_err    = err_q;

endmodule

// File: tb/tb_wishbone_to_ahb.sv
// Directed bench for wishbone_to_ahb: the bench plays both the Wishbone master
// and a scripted AHB slave, with hand-computed expectations.
module tb_wishbone_to_ahb;

  logic        HCLK = 1'b0;
  logic        HRESETn;
  logic        wb_cyc, wb_stb, wb_we;
  logic [3:0]  wb_wstrb;
  logic [31:0] wb_adr, wb_dat_w, wb_dat_r;
  logic        wb_ack, wb_err;
  logic [31:0] HADDR, HWDATA, HRDATA;
  logic [1:0]  HTRANS;
  logic        HWRITE, HMASTLOCK, HREADY, HRESP;
  logic [2:0]  HSIZE, HBURST;
  logic [3:0]  HPROT;

  wishbone_to_ahb dut (
    .HCLK(HCLK), .HRESETn(HRESETn),
    .wb_cyc(wb_cyc), .wb_stb(wb_stb), .wb_we(wb_we), .wb_wstrb(wb_wstrb),
    .wb_adr(wb_adr), .wb_dat_w(wb_dat_w), .wb_dat_r(wb_dat_r),
    .wb_ack(wb_ack), .wb_err(wb_err),
    .HADDR(HADDR), .HTRANS(HTRANS), .HWRITE(HWRITE), .HSIZE(HSIZE),
    .HBURST(HBURST), .HPROT(HPROT), .HMASTLOCK(HMASTLOCK), .HWDATA(HWDATA),
    .HRDATA(HRDATA), .HREADY(HREADY), .HRESP(HRESP)
  );

  always #5 HCLK = ~HCLK;

  int n_chk  = 0;
  int n_pass = 0;
  int xfers  = 0;
  int acks   = 0;
  int errs   = 0;
  int both   = 0;

  // Bus activity counters, sampled on the same edge the DUT sees
  always @(posedge HCLK) begin
    if (HRESETn) begin
      if (HTRANS == 2'b10 && HREADY) xfers <= xfers + 1;
      if (wb_ack) acks <= acks + 1;
      if (wb_err) errs <= errs + 1;
      if (wb_ack && wb_err) both <= both + 1;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
  endtask

  task automatic step();
    @(posedge HCLK);
    #1;
  endtask

  task automatic req(input logic we, input logic [3:0] sel, input logic [31:0] adr,
                     input logic [31:0] dat);
    wb_cyc = 1'b1; wb_stb = 1'b1; wb_we = we; wb_wstrb = sel;
    wb_adr = adr; wb_dat_w = dat;
  endtask

  task automatic release_bus();
    wb_cyc = 1'b0; wb_stb = 1'b0; wb_we = 1'b0; wb_wstrb = 4'h0;
  endtask

  typedef struct {
    logic       we;
    logic [3:0] sel;
    logic       ok;
    logic [2:0] size;
    logic [1:0] lane;
  } dec_t;

  dec_t dec_tab[11] = '{
    '{1'b0, 4'b1111, 1'b1, 3'b010, 2'd0},
    '{1'b1, 4'b0011, 1'b1, 3'b001, 2'd0},
    '{1'b0, 4'b1100, 1'b1, 3'b001, 2'd2},
    '{1'b1, 4'b0001, 1'b1, 3'b000, 2'd0},
    '{1'b0, 4'b0010, 1'b1, 3'b000, 2'd1},
    '{1'b1, 4'b0100, 1'b1, 3'b000, 2'd2},
    '{1'b0, 4'b1000, 1'b1, 3'b000, 2'd3},
    '{1'b0, 4'b0000, 1'b1, 3'b010, 2'd0},
    '{1'b1, 4'b0000, 1'b0, 3'b000, 2'd0},
    '{1'b1, 4'b0110, 1'b0, 3'b000, 2'd0},
    '{1'b0, 4'b1010, 1'b0, 3'b000, 2'd0}
  };

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int x0, a0, e0, seen;
    HRESETn = 1'b0; HREADY = 1'b1; HRESP = 1'b0; HRDATA = '0;
    wb_adr = '0; wb_dat_w = '0;
    release_bus();
    step(); step();

    check("rst_htrans", 32'(HTRANS), 32'h0);
    check("rst_haddr", HADDR, 32'h0);
    check("rst_hwdata", HWDATA, 32'h0);
    check("rst_hsize", 32'(HSIZE), 32'h0);
    check("rst_hwrite", 32'(HWRITE), 32'h0);
    check("rst_dat_r", wb_dat_r, 32'h0);
    check("rst_ack_err", {30'h0, wb_ack, wb_err}, 32'h0);
    check("const_hburst", 32'(HBURST), 32'h0);
    check("const_hprot", 32'(HPROT), 32'h3);
    check("const_lock", 32'(HMASTLOCK), 32'h0);
    HRESETn = 1'b1;
    step();

    // Word read, zero wait states
    HRDATA = 32'hDEAD_BEEF;
    req(1'b0, 4'b1111, 32'h0000_1004, 32'h0);
    step();
    check("rd_htrans_k1", 32'(HTRANS), 32'h2);
    check("rd_haddr", HADDR, 32'h0000_1004);
    check("rd_hsize", 32'(HSIZE), 32'h2);
    check("rd_hwrite", 32'(HWRITE), 32'h0);
    step();
    check("rd_htrans_k2", 32'(HTRANS), 32'h0);
    check("rd_ack_k2", 32'(wb_ack), 32'h0);
    step();
    check("rd_ack_k3", 32'(wb_ack), 32'h1);
    check("rd_dat_r", wb_dat_r, 32'hDEAD_BEEF);
    release_bus();
    step();
    check("rd_ack_pulse", 32'(wb_ack), 32'h0);

    // Byte write, two data-phase wait states
    req(1'b1, 4'b0100, 32'h0000_2000, 32'h00AB_0000);
    step();
    check("bw_htrans", 32'(HTRANS), 32'h2);
    check("bw_haddr", HADDR, 32'h0000_2002);
    check("bw_hsize", 32'(HSIZE), 32'h0);
    check("bw_hwrite", 32'(HWRITE), 32'h1);
    step();
    check("bw_hwdata", HWDATA, 32'h00AB_0000);
    check("bw_htrans_data", 32'(HTRANS), 32'h0);
    HREADY = 1'b0;
    step();
    check("bw_ack_k3", 32'(wb_ack), 32'h0);
    step();
    check("bw_ack_k4", 32'(wb_ack), 32'h0);
    check("bw_hwdata_hold", HWDATA, 32'h00AB_0000);
    HREADY = 1'b1;
    step();
    check("bw_ack_k5", 32'(wb_ack), 32'h1);
    release_bus();
    step();

    // Two-cycle AHB error response
    a0 = acks; e0 = errs;
    req(1'b0, 4'b1111, 32'h0000_3000, 32'h0);
    step();
    step();
    HREADY = 1'b0; HRESP = 1'b1;
    step();
    check("er_first_cycle", {30'h0, wb_ack, wb_err}, 32'h0);
    HREADY = 1'b1;
    step();
    check("er_err", 32'(wb_err), 32'h1);
    check("er_no_ack", 32'(wb_ack), 32'h0);
    HRESP = 1'b0;
    release_bus();
    step();
    check("er_err_pulse", 32'(wb_err), 32'h0);
    check("er_counts", 32'((errs - e0) * 16 + (acks - a0)), 32'h10);

    // Illegal select on a write
    x0 = xfers;
    req(1'b1, 4'b0110, 32'h0000_4000, 32'h1234_5678);
    step();
    check("il_err_k1", 32'(wb_err), 32'h1);
    check("il_htrans", 32'(HTRANS), 32'h0);
    release_bus();
    step();
    check("il_err_pulse", 32'(wb_err), 32'h0);
    step();
    check("il_no_xfer", 32'(xfers - x0), 32'h0);

    // Select decode table, each completed as a zero-wait transfer
    for (int i = 0; i < 11; i++) begin
      req(dec_tab[i].we, dec_tab[i].sel, 32'h0000_0500, 32'hCAFE_F00D);
      step();
      if (dec_tab[i].ok) begin
        check($sformatf("dec%0d_htrans", i), 32'(HTRANS), 32'h2);
        check($sformatf("dec%0d_hsize", i), 32'(HSIZE), 32'(dec_tab[i].size));
        check($sformatf("dec%0d_haddr", i), HADDR, 32'h0000_0500 | 32'(dec_tab[i].lane));
        step(); step();
        check($sformatf("dec%0d_ack", i), 32'(wb_ack), 32'h1);
      end else begin
        check($sformatf("dec%0d_err", i), 32'(wb_err), 32'h1);
        check($sformatf("dec%0d_htrans", i), 32'(HTRANS), 32'h0);
      end
      release_bus();
      step();
    end

    // Back-to-back reads with stb held throughout
    x0 = xfers; a0 = acks; seen = 0;
    HRDATA = 32'hA5A5_0000;
    req(1'b0, 4'b1111, 32'h0000_6000, 32'h0);
    for (int c = 0; c < 40 && seen < 3; c++) begin
      step();
      if (wb_ack) begin
        check($sformatf("b2b_dat%0d", seen), wb_dat_r, 32'hA5A5_0000 + 32'(seen));
        check($sformatf("b2b_idle_in_ack%0d", seen), 32'(HTRANS), 32'h0);
        seen++;
        HRDATA = 32'hA5A5_0000 + 32'(seen);
        if (seen == 3) release_bus();
      end
    end
    check("b2b_seen", 32'(seen), 32'h3);
    step(); step();
    check("b2b_xfers", 32'(xfers - x0), 32'h3);
    check("b2b_acks", 32'(acks - a0), 32'h3);
    check("never_both", 32'(both), 32'h0);

    // HRESP during the address phase is ignored
    HRDATA = 32'h0BAD_F00D;
    req(1'b0, 4'b1111, 32'h0000_7000, 32'h0);
    step();
    HREADY = 1'b0; HRESP = 1'b1;
    step();
    check("ap_hresp_hold", 32'(HTRANS), 32'h2);
    HREADY = 1'b1; HRESP = 1'b0;
    step();
    step();
    check("ap_hresp_ack", {30'h0, wb_ack, wb_err}, 32'h2);
    check("ap_hresp_dat", wb_dat_r, 32'h0BAD_F00D);
    release_bus();
    step();

    // Abort in the data phase: transfer finishes, no ack
    a0 = acks; e0 = errs;
    req(1'b0, 4'b1111, 32'h0000_8000, 32'h0);
    step(); step();
    HREADY = 1'b0;
    release_bus();
    step(); step();
    HREADY = 1'b1;
    step(); step();
    check("ab_no_resp", 32'((acks - a0) + (errs - e0)), 32'h0);
    req(1'b0, 4'b0011, 32'h0000_8100, 32'h0);
    step();
    check("ab_next_accept", HADDR, 32'h0000_8100);
    step(); step();
    check("ab_next_ack", 32'(wb_ack), 32'h1);
    release_bus();
    step();

    // Reset while waiting in the data phase
    req(1'b0, 4'b1111, 32'h0000_9000, 32'h0);
    step(); step();
    HREADY = 1'b0;
    step();
    HRESETn = 1'b0;
    step();
    check("rs_htrans", 32'(HTRANS), 32'h0);
    check("rs_ack", 32'(wb_ack), 32'h0);
    check("rs_haddr", HADDR, 32'h0);
    HRESETn = 1'b1; HREADY = 1'b1;
    release_bus();
    step();
    req(1'b1, 4'b1111, 32'h0000_0040, 32'h1234_5678);
    step();
    check("rs_new_htrans", 32'(HTRANS), 32'h2);
    check("rs_new_haddr", HADDR, 32'h0000_0040);
    step();
    check("rs_new_hwdata", HWDATA, 32'h1234_5678);
    step();
    check("rs_new_ack", 32'(wb_ack), 32'h1);
    release_bus();
    step();
    check("never_both_end", 32'(both), 32'h0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
